// File: rtl/trigger_capture_pkg.sv
// Shared encodings for the trigger capture block and its readout controller.
package trigger_capture_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_ARMED = 3'd2,
    ST_POST  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam logic SLOPE_RISE = 1'b0;
  localparam logic SLOPE_FALL = 1'b1;

endpackage

// File: rtl/trigger_capture_if.sv
// Read side of the async sample FIFO: head data, empty flag and pop strobe.
interface trigger_capture_if #(
  parameter int DATA_SIZE = 8
);
  logic                 empty;
  logic [DATA_SIZE-1:0] data;
  logic                 inc;

  // master = the consumer popping samples, slave = the FIFO read port
  modport master (input empty, input data, output inc);
  modport slave  (output empty, output data, input inc);
endinterface

// File: rtl/trigger_capture_ram.sv
// Capture buffer: single write port, registered read port.
module capture_ram #(
  parameter int DATA_SIZE = 8,
  parameter int ADDR_SIZE = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 w_en_i,
  input  logic [ADDR_SIZE-1:0] w_addr_i,
  input  logic [DATA_SIZE-1:0] w_data_i,
  input  logic [ADDR_SIZE-1:0] r_addr_i,
  output logic [DATA_SIZE-1:0] r_data_o
);
  localparam int DEPTH = 1 << ADDR_SIZE;

  logic [DATA_SIZE-1:0] mem [0:DEPTH-1];
  logic [DATA_SIZE-1:0] r_data_q;

  // array write; contents deliberately not reset
  always_ff @(posedge clk_i) begin
    if (w_en_i) mem[w_addr_i] <= w_data_i;
  end

  // registered readout, cleared on reset so the output is defined
  always_ff @(posedge clk_i) begin
    if (rst_i) r_data_q <= '0;
    else       r_data_q <= mem[r_addr_i];
  end

  assign r_data_o = r_data_q;
endmodule

// File: rtl/trigger_capture.sv
// Pops FIFO samples into a circular history, fires on a level crossing,
// captures a post-trigger window, then freezes for readout.
module trigger_capture
  import trigger_capture_pkg::*;
#(
  parameter int DATA_SIZE     = 8,
  parameter int BUF_ADDR_SIZE = 4,
  parameter int PRE_SAMPLES   = 4,
  parameter int POST_SAMPLES  = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     arm_i,
  input  logic [DATA_SIZE-1:0]     level_i,
  input  logic                     slope_i,
  trigger_capture_if.master        fifo,
  input  logic [BUF_ADDR_SIZE-1:0] rd_addr_i,
  output logic [DATA_SIZE-1:0]     rd_data_o,
  output logic [BUF_ADDR_SIZE-1:0] start_addr_o,
  output logic                     busy_o,
  output logic                     triggered_o,
  output logic                     done_o
);
  localparam int CW = BUF_ADDR_SIZE + 1;
  localparam logic [CW-1:0]            PRE_LAST  = CW'(PRE_SAMPLES - 1);
  localparam logic [CW-1:0]            POST_LAST = CW'(POST_SAMPLES - 1);
  localparam logic [BUF_ADDR_SIZE-1:0] PRE_OFS   = BUF_ADDR_SIZE'(PRE_SAMPLES);

  state_e                   state_q;
  logic [BUF_ADDR_SIZE-1:0] wp_q;
  logic [BUF_ADDR_SIZE-1:0] start_q;
  logic [CW-1:0]            cnt_q;
  logic [DATA_SIZE-1:0]     prev_q;
  logic                     trig_q, busy_q, done_q;
  logic                     accept, fire;

  // pop whenever capturing and data is present; reset overrides the state decode
  assign accept   = ~rst_i & ~fifo.empty &
                    ((state_q == ST_PRE) | (state_q == ST_ARMED) | (state_q == ST_POST));
  assign fifo.inc = accept;

  // edge comparator against the previous accepted sample
  always_comb begin
    fire = 1'b0;
    if (slope_i == SLOPE_RISE) fire = (prev_q < level_i) && (fifo.data >= level_i);
    else                       fire = (prev_q > level_i) && (fifo.data <= level_i);
  end

  // capture FSM, write pointer, counter and registered status outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      wp_q    <= '0;
      start_q <= '0;
      cnt_q   <= '0;
      prev_q  <= '0;
      trig_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      if (accept) wp_q <= wp_q + 1'b1;
      case (state_q)
        ST_IDLE, ST_DONE: if (arm_i) begin
          state_q <= ST_PRE;
          cnt_q   <= '0;
          wp_q    <= '0;
          trig_q  <= 1'b0;
          busy_q  <= 1'b1;
          done_q  <= 1'b0;
        end
        ST_PRE: if (accept) begin
          prev_q <= fifo.data;
          if (cnt_q == PRE_LAST) begin
            state_q <= ST_ARMED;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_ARMED: if (accept) begin
          prev_q <= fifo.data;
          if (fire) begin
            start_q <= wp_q - PRE_OFS;
            trig_q  <= 1'b1;
            state_q <= ST_POST;
          end
        end
        ST_POST: if (accept) begin
          if (cnt_q == POST_LAST) begin
            state_q <= ST_DONE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  capture_ram #(.DATA_SIZE(DATA_SIZE), .ADDR_SIZE(BUF_ADDR_SIZE)) u_ram (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .w_en_i   (accept),
    .w_addr_i (wp_q),
    .w_data_i (fifo.data),
    .r_addr_i (rd_addr_i),
    .r_data_o (rd_data_o)
  );

  assign start_addr_o = start_q;
  assign busy_o       = busy_q;
  assign triggered_o  = trig_q;
  assign done_o       = done_q;
endmodule

// File: tb/tb_trigger_capture.sv
// Directed bench: queue-modelled FIFO, scoreboard of expected capture windows.
module tb_trigger_capture;
  import trigger_capture_pkg::*;

  localparam int DS = 8, AS = 4, DEPTH = 16, PRE = 4, POST = 8, WIN = PRE + 1 + POST;

  logic          clk = 1'b0;
  logic          rst, arm, slope;
  logic [DS-1:0] level, rd_data;
  logic [AS-1:0] rd_addr, start_addr;
  logic          busy, trig, done;

  trigger_capture_if #(.DATA_SIZE(DS)) fifo ();

  trigger_capture dut (
    .clk_i(clk), .rst_i(rst), .arm_i(arm), .level_i(level), .slope_i(slope),
    .fifo(fifo), .rd_addr_i(rd_addr), .rd_data_o(rd_data), .start_addr_o(start_addr),
    .busy_o(busy), .triggered_o(trig), .done_o(done)
  );

  always #5 clk = ~clk;

  logic [DS-1:0] fq[$], stim[$], sb[$];
  logic [DS-1:0] qhead;
  int  qsize, acc_cnt, checks, errors, exp_start;
  bit  pend, gate;

  assign fifo.empty = gate | (qsize == 0);
  assign fifo.data  = qhead;

  function automatic void refresh();
    qsize = fq.size();
    qhead = (qsize > 0) ? fq[0] : '0;
  endfunction

  // FIFO model: pop decision sampled at the edge, applied at the following negedge
  always @(posedge clk) pend = fifo.inc;
  always @(negedge clk) begin
    if (pend) begin
      void'(fq.pop_front());
      acc_cnt++;
      pend = 1'b0;
    end
    refresh();
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk); #1;
  endtask

  // load stim into the FIFO and push the model's expected window to the scoreboard
  task automatic load(input logic [DS-1:0] lvl, input logic slp);
    int t;
    t = -1;
    for (int i = PRE; i < stim.size(); i++)
      if (t < 0) begin
        if (slp == SLOPE_RISE) begin
          if (stim[i-1] < lvl && stim[i] >= lvl) t = i;
        end else begin
          if (stim[i-1] > lvl && stim[i] <= lvl) t = i;
        end
      end
    sb.delete();
    for (int k = 0; k < WIN; k++) sb.push_back(stim[t-PRE+k]);
    exp_start = (t - PRE) % DEPTH;
    fq = stim;
    refresh();
    level = lvl;
    slope = slp;
  endtask

  task automatic arm_pulse();
    arm = 1'b1; tick(); arm = 1'b0;
    acc_cnt = 0;
  endtask

  task automatic wait_acc(input string tag, input int n);
    int k;
    k = 0;
    while (acc_cnt < n && k < 200) begin tick(); k++; end
    check(tag, acc_cnt, n);
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (!done && k < 300) begin tick(); k++; end
    check(tag, done, 1);
  endtask

  task automatic readout(input string tag);
    check({tag, "_start"}, start_addr, exp_start);
    for (int k = 0; k < WIN; k++) begin
      rd_addr = AS'((exp_start + k) % DEPTH);
      tick();
      if (sb.size() == 0) check({tag, "_sb_empty"}, 1, 0);
      else check({tag, "_data"}, rd_data, sb.pop_front());
    end
  endtask

  task automatic stream_rise();
    stim = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd9};
    for (int v = 10; v <= 17; v++) stim.push_back(DS'(v));
  endtask

  initial begin
    int a;
    bit seen6;
    rst = 1'b1; arm = 1'b0; slope = 1'b0; level = '0; rd_addr = '0;
    gate = 1'b0; checks = 0; errors = 0; acc_cnt = 0; refresh();
    repeat (3) tick();
    rst = 1'b0; tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_trig", trig, 0);
    check("rst_start", start_addr, 0);
    check("rst_rd", rd_data, 0);

    // 1: reset mid-PRE
    stream_rise(); load(8'd8, SLOPE_RISE);
    arm_pulse(); tick(); tick();
    check("t1_pre_busy", busy, 1);
    rst = 1'b1; tick();
    check("t1_inc", fifo.inc, 0);
    check("t1_busy", busy, 0);
    check("t1_rd", rd_data, 0);
    tick(); tick(); rst = 1'b0; tick();
    check("t1_idle_inc", fifo.inc, 0);
    check("t1_idle_busy", busy, 0);
    check("t1_trig", trig, 0);
    check("t1_done", done, 0);

    // 2: rising, level 8
    fq.delete(); stream_rise(); load(8'd8, SLOPE_RISE);
    arm_pulse(); wait_done("t2_done");
    check("t2_busy", busy, 0);
    check("t2_trig", trig, 1);
    readout("t2");

    // 3: falling, level 8; must not fire on 12
    stim = '{8'd20, 8'd20, 8'd20, 8'd20, 8'd20, 8'd12, 8'd7, 8'd6,
             8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0, 8'd9};
    load(8'd8, SLOPE_FALL);
    arm_pulse();
    seen6 = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (acc_cnt == 6 && !seen6) begin check("t3_no_trig_12", trig, 0); seen6 = 1'b1; end
      if (acc_cnt == 7) begin check("t3_trig_7", trig, 1); break; end
      tick();
    end
    check("t3_seen6", seen6, 1);
    wait_done("t3_done");
    readout("t3");

    // 4: long ramp, history wraps before the trigger
    stim.delete();
    for (int v = 1; v <= 40; v++) stim.push_back(DS'(v));
    for (int v = 39; v >= 30; v--) stim.push_back(DS'(v));
    load(8'd30, SLOPE_RISE);
    arm_pulse(); wait_done("t4_done");
    readout("t4");

    // 5: FIFO gated empty in ARMED and POST
    stream_rise(); load(8'd8, SLOPE_RISE);
    arm_pulse();
    wait_acc("t5_reach_armed", 5);
    gate = 1'b1; a = acc_cnt;
    repeat (5) begin tick(); check("t5_gate_inc_a", fifo.inc, 0); end
    check("t5_hold_a", acc_cnt, a);
    check("t5_not_trig", trig, 0);
    gate = 1'b0;
    wait_acc("t5_reach_post", 8);
    gate = 1'b1; a = acc_cnt;
    repeat (5) begin tick(); check("t5_gate_inc_p", fifo.inc, 0); end
    check("t5_hold_p", acc_cnt, a);
    check("t5_busy_p", busy, 1);
    gate = 1'b0;
    wait_done("t5_done");
    readout("t5");

    // 6: frozen in DONE, arm ignored while busy, re-arm from DONE
    fq.delete();
    for (int v = 0; v < 5; v++) fq.push_back(DS'(100 + v));
    refresh();
    repeat (5) begin tick(); check("t6_done_inc", fifo.inc, 0); end
    check("t6_qsize", qsize, 5);
    fq.delete(); stream_rise(); load(8'd8, SLOPE_RISE);
    arm_pulse();
    check("t6_rearm_trig", trig, 0);
    check("t6_rearm_done", done, 0);
    check("t6_rearm_busy", busy, 1);
    wait_acc("t6_pre", 2);
    arm = 1'b1; tick(); arm = 1'b0;
    wait_acc("t6_post", 7);
    arm = 1'b1; tick(); arm = 1'b0;
    wait_done("t6_done");
    readout("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
